vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator. A clock divider produces one pix_tick every
// CLK_DIV system clocks; on each tick the column counter xc advances and, at
// end of line, the line counter yc advances. hsync/vsync/de are decoded from
// the registered counters with no added latency, so downstream pixel logic
// can index its data with xc/yc directly in the same cycle.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous active-high reset (dominates en)
//   en          in   run enable; 0 freezes divider and counters
//   pix_tick    out  one-clk pulse per pixel period
//   hsync       out  horizontal sync, active level HSYNC_POL
//   vsync       out  vertical sync, active level VSYNC_POL
//   de          out  display enable (visible area)
//   xc          out  current pixel column
//   yc          out  current line
//   line_start  out  pulse in the cycle whose edge wraps xc to 0
//   frame_start out  pulse in the cycle whose edge wraps (xc,yc) to (0,0)

module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] xc,
    output logic [CW-1:0] yc,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // A divide-by-1 still needs a 1-bit counter so the tick equation stays
    // uniform; it simply never leaves 0.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    // Parameter sanity: reject geometries the counters cannot represent.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("vga_timing_gen: sync widths must be non-zero");
    end
    if (longint'(H_TOTAL) - 1 > (longint'(1) << CW) - 1) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if (longint'(V_TOTAL) - 1 > (longint'(1) << CW) - 1) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end

    logic [DW-1:0] div;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_act;
    logic          vs_act;

    // ------------------------------------------------------------------
    // Strobes: combinational from registered state so they line up with
    // the edge that performs the step/wrap.
    // ------------------------------------------------------------------
    assign pix_tick    = en && (div == DIV_LAST);
    assign h_wrap      = (xc == H_LAST);
    assign v_wrap      = (yc == V_LAST);
    assign line_start  = pix_tick && h_wrap;
    assign frame_start = line_start && v_wrap;

    // ------------------------------------------------------------------
    // Divider. Holds its value while en=0 so a pause never adds or drops
    // a tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Position counters. yc only moves on the tick that wraps xc.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            xc <= '0;
            yc <= '0;
        end else if (pix_tick) begin
            if (h_wrap) begin
                xc <= '0;
                yc <= v_wrap ? '0 : yc + CW'(1);
            end else begin
                xc <= xc + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode. Zero latency relative to xc/yc.
    // ------------------------------------------------------------------
    assign hs_act = (xc >= HS_FIRST) && (xc <= HS_LAST);
    assign vs_act = (yc >= VS_FIRST) && (yc <= VS_LAST);
    assign hsync  = hs_act ? HS_ON : ~HS_ON;
    assign vsync  = vs_act ? VS_ON : ~VS_ON;
    assign de     = (xc < H_VIS) && (yc < V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share one clock:
//   A: default 640x480 timing, CLK_DIV=4 (line-level checks)
//   B: tiny 8x6 raster, CLK_DIV=1, active-high syncs (frame-level checks)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A (defaults) ----------------
    logic       reset_a, en_a;
    logic       pix_tick_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
    logic [9:0] xc_a, yc_a;

    vga_timing_gen dut_a (
        .clk(clk), .reset(reset_a), .en(en_a),
        .pix_tick(pix_tick_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .xc(xc_a), .yc(yc_a),
        .line_start(line_start_a), .frame_start(frame_start_a)
    );

    // ---------------- DUT B (tiny raster) ----------------
    logic       reset_b, en_b;
    logic       pix_tick_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
    logic [3:0] xc_b, yc_b;

    vga_timing_gen #(
        .CLK_DIV(1),
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .CW(4)
    ) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b),
        .pix_tick(pix_tick_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .xc(xc_b), .yc(yc_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- table for B ----------------
    // Expected values describe the cycle in which rst/en are applied
    // (state before the edge plus the combinational outputs).
    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] x;
        logic [3:0] y;
        logic       pix, ls, fs, hs, vs, de;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [13:0] pack_b_act();
        return {xc_b, yc_b, pix_tick_b, line_start_b, frame_start_b, hsync_b, vsync_b, de_b};
    endfunction

    // ---------------- reference model for B ----------------
    int bx, by;

    function automatic logic [13:0] exp_b(input int x, input int y, input logic e);
        logic pix, ls, fs, hs, vs, d;
        pix = e;
        ls  = pix && (x == 7);
        fs  = ls && (y == 5);
        hs  = (x >= 5) && (x <= 6);
        vs  = (y == 4);
        d   = (x < 4) && (y < 3);
        return {4'(x), 4'(y), pix, ls, fs, hs, vs, d};
    endfunction

    int fs_cnt_b;

    task automatic step_b(input logic r, input logic e);
        logic [13:0] a;
        reset_b = r;
        en_b    = e;
        #1;
        a = pack_b_act();
        chk($sformatf("b_model x=%0d y=%0d", bx, by), 32'(a), 32'(exp_b(bx, by, e)));
        if (frame_start_b) fs_cnt_b++;
        if (bx == 7 && by == 5 && e && !r)
            chk("b_simul_wrap", {30'd0, line_start_b, frame_start_b}, 32'd3);
        @(posedge clk);
        if (r) begin
            bx = 0; by = 0;
        end else if (e) begin
            if (bx == 7) begin
                bx = 0;
                by = (by == 5) ? 0 : by + 1;
            end else begin
                bx = bx + 1;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- reference model for A ----------------
    int ax, ay, adiv, acyc;
    int first_tick, ls_seen, ls_cyc0, ls_cyc1, hs_low_cnt, de_cnt;

    task automatic step_a(input logic e);
        logic pix, ls, fs, hs, vs, d;
        en_a = e;
        #1;
        acyc++;
        pix = e && (adiv == 3);
        ls  = pix && (ax == 799);
        fs  = ls && (ay == 524);
        hs  = !((ax >= 656) && (ax <= 751));
        vs  = !((ay >= 490) && (ay <= 491));
        d   = (ax < 640) && (ay < 480);
        chk($sformatf("a_model cyc=%0d x=%0d", acyc, ax),
            {6'd0, pix_tick_a, line_start_a, frame_start_a, hsync_a, vsync_a, de_a, xc_a, yc_a},
            {6'd0, pix, ls, fs, hs, vs, d, 10'(ax), 10'(ay)});
        if (first_tick == 0 && pix_tick_a) first_tick = acyc;
        if (ls_seen == 1) begin
            if (!hsync_a) hs_low_cnt++;
            if (de_a) de_cnt++;
        end
        if (line_start_a) begin
            if (ls_seen == 0) ls_cyc0 = acyc; else ls_cyc1 = acyc;
            ls_seen++;
        end
        @(posedge clk);
        if (e) begin
            if (adiv == 3) begin
                adiv = 0;
                if (ax == 799) begin
                    ax = 0;
                    ay = (ay == 524) ? 0 : ay + 1;
                end else begin
                    ax = ax + 1;
                end
            end else begin
                adiv = adiv + 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;

        tbl[0]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'd7, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        ax = 0; ay = 0; adiv = 0; acyc = 0;
        first_tick = 0; ls_seen = 0; ls_cyc0 = 0; ls_cyc1 = 0;
        hs_low_cnt = 0; de_cnt = 0;
        bx = 0; by = 0; fs_cnt_b = 0;

        reset_a = 1'b1; en_a = 1'b1;
        reset_b = 1'b1; en_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state (en_a=1 held during reset).
        chk("a_rst_xc", 32'(xc_a), 32'd0);
        chk("a_rst_yc", 32'(yc_a), 32'd0);
        chk("a_rst_pix", 32'(pix_tick_a), 32'd0);
        chk("a_rst_strobes", {30'd0, line_start_a, frame_start_a}, 32'd0);
        chk("a_rst_de_hs_vs", {29'd0, de_a, hsync_a, vsync_a}, 32'd7);
        chk("b_rst_de_hs_vs", {29'd0, de_b, hsync_b, vsync_b}, 32'd4);

        // Table vectors on B.
        for (int i = 0; i < 14; i++) begin
            reset_b = tbl[i].rst;
            en_b    = tbl[i].en;
            #1;
            chk($sformatf("b_vec%0d", i), 32'(pack_b_act()),
                32'({tbl[i].x, tbl[i].y, tbl[i].pix, tbl[i].ls, tbl[i].fs,
                     tbl[i].hs, tbl[i].vs, tbl[i].de}));
            @(negedge clk);
        end

        // B: exhaustive model compare over 3 frames from reset.
        reset_b = 1'b1; @(negedge clk);
        bx = 0; by = 0; fs_cnt_b = 0;
        for (int i = 0; i < 144; i++) step_b(1'b0, 1'b1);
        chk("b_frame_count", 32'(fs_cnt_b), 32'd3);
        chk("b_back_at_origin", {24'd0, xc_b, yc_b}, 32'd0);

        // B: reset mid-frame at (6,4) with syncs active.
        for (int i = 0; i < 38; i++) step_b(1'b0, 1'b1);
        chk("b_pre_rst_pos", {24'd0, xc_b, yc_b}, {24'd0, 4'd6, 4'd4});
        step_b(1'b1, 1'b1);
        chk("b_post_rst", {18'd0, pack_b_act()}, {18'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 10; i++) step_b(1'b0, 1'b1);

        // A: release reset with en=1; run to xc=100, div=2.
        reset_a = 1'b0;
        guard = 0;
        while (!(ax == 100 && adiv == 2) && guard < 1000) begin
            step_a(1'b1);
            guard++;
        end
        chk("a_first_tick_clk", 32'(first_tick), 32'd4);
        chk("a_reach_x100", 32'(guard < 1000), 32'd1);

        // Freeze 10 clocks.
        for (int i = 0; i < 10; i++) step_a(1'b0);
        chk("a_frozen_xc", 32'(xc_a), 32'd100);
        step_a(1'b1);
        chk("a_resume_tick", {31'd0, pix_tick_a}, 32'd1);
        step_a(1'b1);
        chk("a_resume_xc", 32'(xc_a), 32'd101);

        // A: run through two line wraps.
        guard = 0;
        while (ls_seen < 2 && guard < 8000) begin
            step_a(1'b1);
            guard++;
        end
        chk("a_two_lines", 32'(ls_seen), 32'd2);
        chk("a_line_period", 32'(ls_cyc1 - ls_cyc0), 32'd3200);
        chk("a_hsync_low_clks", 32'(hs_low_cnt), 32'd384);
        chk("a_de_high_clks", 32'(de_cnt), 32'd2560);
        chk("a_yc_after_2", 32'(yc_a), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
